shiftregs_rx: RTL and testbench

//  Receive side of the static/dynamic shift-register configuration link driven by fsm_shiftRegs.

---
 rtl/shiftregs_rx.sv | 122 ++++++++++++
 tb/tb_shiftregs_rx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/shiftregs_rx.sv
// rtl/shiftregs_rx.sv - receive side of the static/dynamic shift-register configuration link
// Optional SHIFTREGS_RX_STICKY_ERR_EN: adds clr_err and makes err_len/err_proto sticky.
module shiftregs_rx #(
   parameter int SIZESRSTAT  = 88,
   parameter int SIZESRDYN   = 16,
   parameter int SIZEADDRMUX = 7
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  sel_stat,
   input  logic                  sel_dyn,
   input  logic                  en_fin,
   input  logic                  signal_in,
`ifdef SHIFTREGS_RX_STICKY_ERR_EN
   input  logic                  clr_err,
`endif
   output logic [SIZESRSTAT-1:0] stat_out,
   output logic [SIZESRDYN-1:0]  dyn_out,
   output logic                  frame_valid,
   output logic                  err_len,
   output logic                  err_proto
);

   typedef enum logic [1:0] {IDLE, SHIFT_STAT, SHIFT_DYN, WAIT_FIN} state_t;

   localparam logic [SIZEADDRMUX-1:0] C_STAT = SIZEADDRMUX'(SIZESRSTAT);
   localparam logic [SIZEADDRMUX-1:0] C_DYN  = SIZEADDRMUX'(SIZESRDYN);

   state_t                 r_state;
   logic [SIZESRSTAT-1:0]  r_shadow_stat;
   logic [SIZESRDYN-1:0]   r_shadow_dyn;
   logic [SIZEADDRMUX-1:0] r_cnt_stat;
   logic [SIZEADDRMUX-1:0] r_cnt_dyn;
   logic [SIZESRSTAT-1:0]  r_stat_out;
   logic [SIZESRDYN-1:0]   r_dyn_out;
   logic                   r_frame_valid;
   logic                   r_err_len;
   logic                   r_err_proto;

   logic w_sel_any, w_both, w_shift_stat, w_shift_dyn;
   logic w_len_ok, w_commit, w_set_len, w_set_proto, w_keep_err;

   assign w_sel_any    = sel_stat | sel_dyn;
   assign w_both       = sel_stat & sel_dyn;
   assign w_shift_stat = ~en_fin & sel_stat & ~sel_dyn;
   assign w_shift_dyn  = ~en_fin & sel_dyn & ~sel_stat;
   assign w_len_ok     = (r_cnt_stat == C_STAT) && (r_cnt_dyn == C_DYN);
   assign w_commit     = en_fin & ~w_sel_any & w_len_ok;
   assign w_set_len    = en_fin & ~w_sel_any & ~w_len_ok;
   // A sel collision, or a sel coinciding with the end strobe, is a framing fault.
   assign w_set_proto  = w_both | (en_fin & w_sel_any);

`ifdef SHIFTREGS_RX_STICKY_ERR_EN
   assign w_keep_err = ~clr_err;
`else
   assign w_keep_err = 1'b0;
`endif

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state <= IDLE;
      end else if (en_fin) begin
         r_state <= IDLE;
      end else if (!w_both) begin
         case (r_state)
            SHIFT_STAT: r_state <= sel_stat ? SHIFT_STAT : (sel_dyn ? SHIFT_DYN : WAIT_FIN);
            SHIFT_DYN:  r_state <= sel_dyn ? SHIFT_DYN : (sel_stat ? SHIFT_STAT : WAIT_FIN);
            default: begin
               if (sel_stat)     r_state <= SHIFT_STAT;
               else if (sel_dyn) r_state <= SHIFT_DYN;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_shadow_stat <= '0;
         r_shadow_dyn  <= '0;
         r_cnt_stat    <= '0;
         r_cnt_dyn     <= '0;
      end else if (en_fin) begin
         r_cnt_stat <= '0;
         r_cnt_dyn  <= '0;
      end else begin
         // Counters saturate so an over-long segment can never wrap back to a legal length.
         if (w_shift_stat) begin
            r_shadow_stat <= {r_shadow_stat[SIZESRSTAT-2:0], signal_in};
            if (r_cnt_stat != '1) r_cnt_stat <= r_cnt_stat + 1'b1;
         end
         if (w_shift_dyn) begin
            r_shadow_dyn <= {r_shadow_dyn[SIZESRDYN-2:0], signal_in};
            if (r_cnt_dyn != '1) r_cnt_dyn <= r_cnt_dyn + 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_stat_out    <= '0;
         r_dyn_out     <= '0;
         r_frame_valid <= 1'b0;
         r_err_len     <= 1'b0;
         r_err_proto   <= 1'b0;
      end else begin
         if (w_commit) begin
            r_stat_out <= r_shadow_stat;
            r_dyn_out  <= r_shadow_dyn;
         end
         r_frame_valid <= w_commit;
         r_err_len     <= w_set_len | (r_err_len & w_keep_err);
         r_err_proto   <= w_set_proto | (r_err_proto & w_keep_err);
      end
   end

   assign stat_out    = r_stat_out;
   assign dyn_out     = r_dyn_out;
   assign frame_valid = r_frame_valid;
   assign err_len     = r_err_len;
   assign err_proto   = r_err_proto;

endmodule

// File: tb/tb_shiftregs_rx.sv
// tb/tb_shiftregs_rx.sv - randomized self-checking bench for shiftregs_rx
// Reference keeps received bits in queues; works with or without SHIFTREGS_RX_STICKY_ERR_EN.
module tb_shiftregs_rx;
   localparam int SS  = 88;
   localparam int SD  = 16;
   localparam int SAT = 127;

   logic          CLK = 1'b0;
   logic          RST_N = 1'b0;
   logic          sel_stat = 1'b0, sel_dyn = 1'b0, en_fin = 1'b0, signal_in = 1'b0, clr_err = 1'b0;
   logic [SS-1:0] stat_out;
   logic [SD-1:0] dyn_out;
   logic          frame_valid, err_len, err_proto;

   int n_checks = 0;
   int n_errors = 0;

`ifdef SHIFTREGS_RX_STICKY_ERR_EN
   localparam bit STICKY = 1'b1;
`else
   localparam bit STICKY = 1'b0;
`endif

   shiftregs_rx #(.SIZESRSTAT(SS), .SIZESRDYN(SD), .SIZEADDRMUX(7)) dut (
      .CLK(CLK), .RST_N(RST_N), .sel_stat(sel_stat), .sel_dyn(sel_dyn),
      .en_fin(en_fin), .signal_in(signal_in),
`ifdef SHIFTREGS_RX_STICKY_ERR_EN
      .clr_err(clr_err),
`endif
      .stat_out(stat_out), .dyn_out(dyn_out), .frame_valid(frame_valid),
      .err_len(err_len), .err_proto(err_proto)
   );

   always #5 CLK = ~CLK;

   // Reference: the last SIZE bits of each segment live in a queue, oldest first (= MSB).
   bit            q_s[$];
   bit            q_d[$];
   int            cnt_s = 0, cnt_d = 0;
   logic [SS-1:0] e_stat = '0;
   logic [SD-1:0] e_dyn = '0;
   logic          e_fv = 0, e_len = 0, e_proto = 0;
   bit            check_en = 0;

   function automatic logic [127:0] pack(input bit q[$]);
      logic [127:0] w = '0;
      foreach (q[i]) w = {w[126:0], q[i]};
      return w;
   endfunction

   task automatic model_clear();
      q_s.delete(); q_d.delete();
      cnt_s = 0; cnt_d = 0;
      e_stat = '0; e_dyn = '0; e_fv = 0; e_len = 0; e_proto = 0;
   endtask

   task automatic model_step();
      bit sl = 0, sp = 0, fv = 0;
      logic [127:0] w;
      if (en_fin) begin
         if (sel_stat || sel_dyn) sp = 1;
         else if (cnt_s == SS && cnt_d == SD) begin
            w = pack(q_s); e_stat = w[SS-1:0];
            w = pack(q_d); e_dyn  = w[SD-1:0];
            fv = 1;
         end else sl = 1;
         cnt_s = 0; cnt_d = 0;
      end else if (sel_stat && sel_dyn) sp = 1;
      else if (sel_stat) begin
         q_s.push_back(signal_in);
         if (q_s.size() > SS) void'(q_s.pop_front());
         if (cnt_s < SAT) cnt_s++;
      end else if (sel_dyn) begin
         q_d.push_back(signal_in);
         if (q_d.size() > SD) void'(q_d.pop_front());
         if (cnt_d < SAT) cnt_d++;
      end
      e_fv    = fv;
      e_len   = sl | (STICKY & e_len & ~clr_err);
      e_proto = sp | (STICKY & e_proto & ~clr_err);
   endtask

   always @(negedge CLK) begin
      if (check_en) begin
         n_checks += 5;
         if (stat_out !== e_stat) begin n_errors++; $display("FAIL stat_out got %h want %h", stat_out, e_stat); end
         if (dyn_out !== e_dyn) begin n_errors++; $display("FAIL dyn_out got %h want %h", dyn_out, e_dyn); end
         if (frame_valid !== e_fv) begin n_errors++; $display("FAIL frame_valid got %b want %b", frame_valid, e_fv); end
         if (err_len !== e_len) begin n_errors++; $display("FAIL err_len got %b want %b", err_len, e_len); end
         if (err_proto !== e_proto) begin n_errors++; $display("FAIL err_proto got %b want %b", err_proto, e_proto); end
      end
   end

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s got %h want %h", name, got, want);
      end
   endtask

   // Entered and left at posedge+1; inputs are stable across the sampling edge.
   task automatic cyc(input logic ss, input logic sd, input logic fin, input logic b, input logic clr);
      sel_stat = ss; sel_dyn = sd; en_fin = fin; signal_in = b; clr_err = clr;
      @(posedge CLK);
      model_step();
      #1;
      sel_stat = 0; sel_dyn = 0; en_fin = 0; signal_in = 0; clr_err = 0;
   endtask

   task automatic send_seg(input bit is_stat, input logic [127:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) cyc(is_stat, !is_stat, 1'b0, v[i], 1'b0);
   endtask

   task automatic do_reset();
      RST_N = 0;
      sel_stat = 0; sel_dyn = 0; en_fin = 0; signal_in = 0; clr_err = 0;
      model_clear();
      #1;
      chk("reset_stat", 128'(stat_out), 128'd0);
      chk("reset_dyn", 128'(dyn_out), 128'd0);
      chk("reset_flags", {125'd0, frame_valid, err_len, err_proto}, 128'd0);
      @(posedge CLK);
      #1;
      RST_N = 1;
   endtask

   task automatic rand_frame();
      int kind, ns, nd, rs, rd, chunk;
      bit seg_s;
      kind = int'($urandom_range(0, 5));
      ns = SS; nd = SD;
      if (kind == 1) ns = SS + int'($urandom_range(0, 4)) - 2;
      if (kind == 2) nd = SD + int'($urandom_range(0, 4)) - 2;
      if (kind == 3) begin ns = int'($urandom_range(0, 2)); nd = int'($urandom_range(0, 2)); end
      rs = ns; rd = nd;
      while (rs > 0 || rd > 0) begin
         if (rs == 0) seg_s = 0;
         else if (rd == 0) seg_s = 1;
         else seg_s = 1'($urandom_range(0, 1));
         chunk = int'($urandom_range(1, 40));
         if (seg_s && chunk > rs) chunk = rs;
         if (!seg_s && chunk > rd) chunk = rd;
         for (int i = 0; i < chunk; i++) begin
            cyc(seg_s, !seg_s, 1'b0, 1'($urandom), 1'b0);
            if (kind == 4 && $urandom_range(0, 30) == 0) cyc(1'b1, 1'b1, 1'b0, 1'($urandom), 1'b0);
         end
         if ($urandom_range(0, 3) == 0) cyc(1'b0, 1'b0, 1'b0, 1'($urandom), 1'b0);
         if (seg_s) rs -= chunk; else rd -= chunk;
      end
      if (kind == 5) begin
         seg_s = 1'($urandom_range(0, 1));
         cyc(seg_s, !seg_s, 1'b1, 1'($urandom), 1'b0);
      end else cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = int'($urandom_range(0, 2)); i > 0; i--)
         cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 7) == 0));
   endtask

   initial begin
      logic [127:0] pat_s, pat_d;
      pat_s = 128'(88'hA5A5_A5A5_A5A5_A5A5_A5A5_5A);
      pat_d = 128'(16'hBEEF);

      do_reset();
      check_en = 1;

      send_seg(1'b1, pat_s, SS);
      send_seg(1'b0, pat_d, SD);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      @(negedge CLK);
      chk("good_stat", 128'(stat_out), pat_s);
      chk("good_dyn", 128'(dyn_out), pat_d);
      chk("good_fv", 128'(frame_valid), 128'd1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge CLK);
      chk("good_fv_off", 128'(frame_valid), 128'd0);

      send_seg(1'b1, 128'h1234, SS - 1);
      send_seg(1'b0, 128'h4321, SD);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      @(negedge CLK);
      chk("short_len", 128'(err_len), 128'd1);
      chk("short_keep_stat", 128'(stat_out), pat_s);
      chk("short_keep_dyn", 128'(dyn_out), pat_d);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      // Overlap mid-frame: the collided bit is dropped, the rest of the frame still fits.
      send_seg(1'b0, 128'h00C3, SD);
      send_seg(1'b1, 128'hFF, 40);
      cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      @(negedge CLK);
      chk("overlap_proto", 128'(err_proto), 128'd1);
      send_seg(1'b1, 128'h0, SS - 40);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      @(negedge CLK);
      chk("overlap_commit_dyn", 128'(dyn_out), 128'h00C3);
      chk("overlap_commit_stat", 128'(stat_out), {40'd0, 40'hFF, 48'd0});

      send_seg(1'b1, 128'hABC, 40);
      do_reset();
      send_seg(1'b1, 128'h1, SS);
      send_seg(1'b0, 128'h8001, SD);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      @(negedge CLK);
      chk("post_reset_stat", 128'(stat_out), 128'h1);
      chk("post_reset_dyn", 128'(dyn_out), 128'h8001);

      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      @(negedge CLK);
      chk("zero_bits_len", 128'(err_len), 128'd1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge CLK);
      chk("len_after_1", 128'(err_len), 128'(STICKY));
      for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      send_seg(1'b0, 128'h5555, SD);
      send_seg(1'b1, pat_s, SS);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      @(negedge CLK);
      chk("len_after_good", 128'(err_len), 128'(STICKY));
      chk("dyn_first_commit", 128'(dyn_out), 128'h5555);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      @(negedge CLK);
      chk("len_cleared", 128'(err_len), 128'd0);

      for (int f = 0; f < 40; f++) rand_frame();

      check_en = 0;
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout got running want finished");
      $fatal(1);
   end
endmodule
